// File: rtl/risc0_io_ctrl.sv
// Memory-mapped IO controller for the RISC0 core: ms timer, switch sync, LEDs, UART TX, RX FIFO.
// Optional timer-compare interrupt at register index 4 is enabled with `define IO_IRQ_EN.
module risc0_io_ctrl #(
  parameter int DIV        = 25000,
  parameter int SW_W       = 8,
  parameter int LED_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iord,
  input  logic             iowr,
  input  logic [5:0]       ioadr,
  input  logic [31:0]      outbus,
  output logic [31:0]      inbus,
  input  logic [SW_W-1:0]  swi,
  output logic [LED_W-1:0] leds,
  input  logic [7:0]       dataRx,
  input  logic             rdyRx,
  output logic             doneRx,
  output logic [7:0]       dataTx,
  output logic             startTx,
  input  logic             rdyTx,
  output logic             irq
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} rx_st_t;

  logic [3:0]        idx;
  logic              wr0, wr1, wr2, wr3, rd2;
  logic [CW-1:0]     cnt0;
  logic [31:0]       cnt1;
  logic              ms_tick;
  logic [SW_W-1:0]   swi_s1, swi_s2;
  logic              txdrop, ovf;
  rx_st_t            state, nstate;
  logic              push, push_ok, pop, full, drop;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       count;
  logic [7:0]        count_b;
  logic              unused_bits;

  assign idx     = ioadr[5:2];
  assign wr0     = iowr && (idx == 4'd0);
  assign wr1     = iowr && (idx == 4'd1);
  assign wr2     = iowr && (idx == 4'd2);
  assign wr3     = iowr && (idx == 4'd3);
  assign rd2     = iord && (idx == 4'd2);
  assign ms_tick = (cnt0 == CW'(DIV - 1));
  assign count_b = 8'(count);
  assign unused_bits = ^{ioadr[1:0], outbus};

  // Timer: a clear write beats the millisecond increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (wr0) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (ms_tick) begin
      cnt0 <= '0;
      cnt1 <= cnt1 + 32'd1;
    end else begin
      cnt0 <= cnt0 + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swi_s1  <= '0;
      swi_s2  <= '0;
      leds    <= '0;
      dataTx  <= '0;
      startTx <= 1'b0;
      txdrop  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      swi_s1  <= swi;
      swi_s2  <= swi_s1;
      startTx <= 1'b0;
      if (wr1) leds <= outbus[LED_W-1:0];
      if (wr2 && rdyTx) begin
        dataTx  <= outbus[7:0];
        startTx <= 1'b1;
      end
      // sticky flags: clear first so a same-cycle set wins
      if (wr3 && outbus[3]) txdrop <= 1'b0;
      if (wr2 && !rdyTx)    txdrop <= 1'b1;
      if (wr3 && outbus[2]) ovf <= 1'b0;
      if (drop)             ovf <= 1'b1;
    end
  end

  // RX handshake: capture once, acknowledge, then wait for rdyRx to drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    push   = 1'b0;
    doneRx = 1'b0;
    case (state)
      S_IDLE: if (rdyRx) begin
        push   = 1'b1;
        nstate = S_ACK;
      end
      S_ACK: begin
        doneRx = 1'b1;
        nstate = S_WAIT;
      end
      S_WAIT: if (!rdyRx) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // A same-cycle pop frees the slot for a push into a full FIFO
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd2 && (count != '0);
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= dataRx;
  end

`ifdef IO_IRQ_EN
  logic [31:0] cmp;
  logic        armed, irq_hit;

  assign irq_hit = armed && ms_tick && !wr0 && ((cnt1 + 32'd1) == cmp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp   <= '0;
      armed <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (iowr && (idx == 4'd4)) begin
        cmp   <= outbus;
        armed <= 1'b1;
      end else if (irq_hit) begin
        armed <= 1'b0;
      end
      if (irq_hit)                           irq <= 1'b1;
      else if ((iord || iowr) && idx == 4'd4) irq <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    inbus = '0;
    case (idx)
      4'd0: inbus = cnt1;
      4'd1: inbus = 32'(swi_s2);
      4'd2: if (count != '0) inbus = {24'b0, mem[rp]};
      4'd3: inbus = {16'b0, count_b, 4'b0, txdrop, ovf, rdyTx, count != '0};
`ifdef IO_IRQ_EN
      4'd4: inbus = cmp;
`endif
      default: inbus = '0;
    endcase
  end
endmodule

// File: tb/tb_risc0_io_ctrl.sv
// Randomized self-checking bench for risc0_io_ctrl against a queue/arithmetic reference model.
module tb_risc0_io_ctrl;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1, iord = 1'b0, iowr = 1'b0;
  logic [5:0]  ioadr = '0;
  logic [31:0] outbus = '0, inbus;
  logic [7:0]  swi = '0, leds, dataRx = '0, dataTx;
  logic        rdyRx = 1'b0, doneRx, startTx, rdyTx = 1'b1, irq;

  int n_chk = 0, n_pass = 0;
  int unsigned cyc = 0, base = 0;
  byte unsigned q[$];
  bit m_ovf = 1'b0, m_txd = 1'b0;

  risc0_io_ctrl #(.DIV(DIV), .SW_W(8), .LED_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iord(iord), .iowr(iowr), .ioadr(ioadr), .outbus(outbus),
    .inbus(inbus), .swi(swi), .leds(leds), .dataRx(dataRx), .rdyRx(rdyRx),
    .doneRx(doneRx), .dataTx(dataTx), .startTx(startTx), .rdyTx(rdyTx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] cnt1_exp();
    return (cyc - base) / DIV;
  endfunction

  function automatic logic [31:0] stat_exp();
    return {16'b0, 8'(q.size()), 4'b0, m_txd, m_ovf, rdyTx, q.size() != 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    ioadr = 6'(idx << 2);
    #1 d = inbus;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    ioadr  = 6'(idx << 2);
    outbus = d;
    iowr   = 1'b1;
    tick();
    iowr = 1'b0;
    if (idx == 0) base = cyc;
  endtask

  task automatic pop(input string tag);
    logic [31:0] e;
    e = (q.size() != 0) ? {24'b0, q[0]} : 32'd0;
    ioadr = 6'd8;
    iord  = 1'b1;
    #1 chk(tag, inbus, e);
    tick();
    iord = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic inject(input byte unsigned b);
    dataRx = b;
    rdyRx  = 1'b1;
    tick();
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
    tick();
    rdyRx = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  old_sw, new_sw, b, last_tx;
    int n;

    #1 rst = 1'b0;
    #2;
    chk("rst_leds", leds, 0);
    chk("rst_dataTx", dataTx, 0);
    chk("rst_startTx", startTx, 0);
    chk("rst_doneRx", doneRx, 0);
    chk("rst_irq", irq, 0);
    rd(3, d); chk("rst_status", d, stat_exp());
    rd(0, d); chk("rst_cnt1", d, 0);
    @(posedge clk); #1 rst = 1'b1;
    base = cyc;

    // timer
    repeat (40) tick();
    rd(0, d); chk("cnt1_40cyc", d, 32'd10);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 30)) tick();
      rd(0, d); chk("cnt1_rand", d, cnt1_exp());
    end
    wr(0, $urandom);
    rd(0, d); chk("cnt1_clear", d, 0);
    repeat (DIV - 1) tick();
    rd(0, d); chk("cnt0_restart_lo", d, 0);
    tick();
    rd(0, d); chk("cnt0_restart_hi", d, 1);

    // leds
    wr(1, 32'hA5); chk("leds_a5", leds, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      wr(1, d); chk("leds_rand", leds, d[7:0]);
    end

    // switch synchroniser latency
    old_sw = 8'h00;
    for (int k = 0; k < 3; k++) begin
      new_sw = (k == 0) ? 8'h3C : (old_sw ^ 8'($urandom_range(1, 255)));
      swi = new_sw;
      rd(1, d); chk("swi_cyc1", d, {24'b0, old_sw});
      tick(); rd(1, d); chk("swi_cyc2", d, {24'b0, old_sw});
      tick(); rd(1, d); chk("swi_cyc3", d, {24'b0, new_sw});
      old_sw = new_sw;
    end

    // single receive held high: one ack only
    b = 8'($urandom);
    dataRx = b; rdyRx = 1'b1; n = 0;
    chk("done_before", doneRx, 0);
    repeat (5) begin
      tick();
      if (doneRx) n++;
    end
    chk("done_pulses", n, 1);
    q.push_back(b);
    rdyRx = 1'b0; tick();
    rd(3, d); chk("rx1_status", d, stat_exp());
    pop("rx1_data");
    rd(3, d); chk("rx1_status_empty", d, stat_exp());

    // overflow
    repeat (5) inject(8'($urandom));
    rd(3, d); chk("ovf_status", d, stat_exp());
    repeat (4) pop("ovf_drain");
    pop("empty_read");
    rd(3, d); chk("empty_status", d, stat_exp());
    wr(3, 32'h4); m_ovf = 1'b0;
    rd(3, d); chk("ovf_clear", d, stat_exp());

    // push and pop in the same cycle while full
    repeat (DEPTH) inject(8'($urandom));
    rd(3, d); chk("full_status", d, stat_exp());
    b = 8'($urandom);
    dataRx = b; rdyRx = 1'b1; ioadr = 6'd8; iord = 1'b1;
    #1 chk("pushpop_head", inbus, {24'b0, q[0]});
    tick();
    iord = 1'b0;
    void'(q.pop_front()); q.push_back(b);
    tick(); rdyRx = 1'b0; tick();
    rd(3, d); chk("pushpop_status", d, stat_exp());

    // overflow set beats a same-cycle clear
    dataRx = 8'($urandom); rdyRx = 1'b1;
    ioadr = 6'd12; outbus = 32'h4; iowr = 1'b1;
    tick();
    iowr = 1'b0; m_ovf = 1'b1;
    tick(); rdyRx = 1'b0; tick();
    rd(3, d); chk("setwins_status", d, stat_exp());
    repeat (DEPTH) pop("setwins_drain");
    wr(3, 32'h4); m_ovf = 1'b0;
    rd(3, d); chk("setwins_clear", d, stat_exp());

    // transmit
    last_tx = 8'h00;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h55 : 8'($urandom);
      rdyTx = 1'b1;
      wr(2, {24'($urandom), b});
      chk("tx_start", startTx, 1);
      chk("tx_data", dataTx, b);
      tick(); chk("tx_start_end", startTx, 0);
      last_tx = b;
    end
    rdyTx = 1'b0;
    wr(2, 32'($urandom));
    chk("txdrop_nostart", startTx, 0);
    chk("txdrop_data", dataTx, last_tx);
    m_txd = 1'b1;
    rd(3, d); chk("txdrop_status", d, stat_exp());
    wr(3, 32'h8); m_txd = 1'b0;
    rd(3, d); chk("txdrop_clear", d, stat_exp());
    rdyTx = 1'b1;

    // unmapped indices
    for (int i = 5; i < 16; i++) begin
      rd(i, d); chk("unmapped", d, 0);
    end

`ifdef IO_IRQ_EN
    wr(0, 0);
    wr(4, 32'd3);
    rd(4, d); chk("cmp_read", d, 3);
    repeat (20) begin
      tick(); chk("irq_rise", irq, cnt1_exp() >= 3);
    end
    ioadr = 6'd16; iord = 1'b1;
    #1 chk("cmp_read2", inbus, 3);
    tick(); iord = 1'b0;
    chk("irq_clear", irq, 0);
    repeat (20) tick();
    chk("irq_disarmed", irq, 0);
`else
    wr(4, 32'd3);
    rd(4, d); chk("idx4_zero", d, 0);
    for (int k = 0; k < 4; k++) begin
      repeat (10) tick();
      chk("irq_tied", irq, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/risc0_io_ctrl.md
Name: risc0_io_ctrl

Overview:
Parametrised memory-mapped IO controller for the RISC0 core, sitting between the CPU IO port (iord/iowr/ioadr/inbus/outbus) and the board peripherals. It provides a millisecond timer, a synchronised switch input, an LED output register, a UART transmit handshake, and a receive FIFO that drains the RS232 receiver autonomously. It replaces the hand-written IO decode in the top level with one reusable block.

Parameters:
DIV, 25000, clk cycles per timer tick (25 MHz clock -> 1 ms)
SW_W, 8, switch input width (1..32)
LED_W, 8, LED register width (1..32)
FIFO_DEPTH, 8, RX FIFO entries, power of two, 2..256

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
iord  in  1  CPU IO read strobe, one cycle
iowr  in  1  CPU IO write strobe, one cycle
ioadr  in  6  CPU IO address; register index = ioadr[5:2]
outbus  in  32  CPU write data
inbus  out  32  CPU read data, combinational from ioadr and state
swi  in  SW_W  asynchronous switch inputs
leds  out  LED_W  LED register
dataRx  in  8  receiver byte
rdyRx  in  1  receiver holds a byte
doneRx  out  1  one-cycle acknowledge to receiver
dataTx  out  8  transmit byte, registered
startTx  out  1  one-cycle transmit start
rdyTx  in  1  transmitter idle
irq  out  1  timer compare interrupt (see Optional Feature)

Behaviour:
- Reset (rst=0, async): cnt0=0, cnt1=0, leds=0, dataTx=0, startTx=0, doneRx=0, FIFO empty, ovf=0, txdrop=0, swi sync flops=0, irq=0, RX FSM=IDLE.
- Register map (index ioadr[5:2]); reads of unmapped indices return 0, writes ignored:
  - 0 R: cnt1 (ms count). W: cnt1<=0, cnt0<=0.
  - 1 R: swi after 2-flop sync, zero-extended. W: leds<=outbus[LED_W-1:0].
  - 2 R: FIFO head byte zero-extended; iord pops one entry; empty -> returns 0, no pop. W: TX byte.
  - 3 R: {16'b0, count[7:0], 4'b0, txdrop, ovf, rdyTx, nonempty}. W: outbus[3]=1 clears txdrop, outbus[2]=1 clears ovf.
  - 4 R/W: compare register (feature only).
- Timer: cnt0 counts 0..DIV-1; at DIV-1 wraps to 0 and cnt1 increments (32-bit, wraps 0xFFFFFFFF->0). Write to index 0 has priority over increment.
- TX: iowr to index 2 with rdyTx=1 -> next cycle dataTx=outbus[7:0], startTx=1 for exactly one cycle. With rdyTx=0 -> write dropped, txdrop<=1, startTx stays 0.
- RX FSM, states IDLE, ACK, WAIT:
  - IDLE: rdyRx=1 -> push dataRx if not full, else drop byte and set ovf; go ACK.
  - ACK: doneRx=1 for this one cycle; go WAIT.
  - WAIT: stay until rdyRx=0, then IDLE (prevents double capture).
- FIFO: count 0..FIFO_DEPTH, pointers wrap modulo FIFO_DEPTH. Push and pop in same cycle: both happen, count unchanged; a pop while full frees space so a same-cycle push is accepted, no ovf. Push while full without pop: ovf.
- Read data is combinational; the pop takes effect on the clock edge ending the iord cycle.
- Sticky flags set and cleared in the same cycle: set wins.

Optional Feature:
IO_IRQ_EN defined: 32-bit compare register at index 4 (reset 0), and armed bit. Writing index 4 loads compare and sets armed. When cnt1 increments to equal compare while armed, irq<=1 and armed<=0. irq stays high until any iord or iowr to index 4. Undefined: no compare logic, index 4 reads 0, irq tied 0.

Test Plan:
- Reset then DIV=4, run 40 cycles -> cnt1=10; write index 0 -> cnt1 reads 0 next cycle, cnt0 restarts.
- Write 0xA5 to index 1 -> leds=0xA5. Drive swi=0x3C -> index 1 reads 0x3C from the third cycle on.
- rdyRx=1 with dataRx=0x41, held 5 cycles -> exactly one doneRx pulse, status count=1, index 2 reads 0x41, then count=0.
- FIFO_DEPTH=4, inject 5 bytes -> count=4, ovf=1, first 4 bytes read back in order. Write 0x4 to index 3 -> ovf=0.
- Write 0x55 to index 2 with rdyTx=1 -> one startTx pulse, dataTx=0x55. Repeat with rdyTx=0 -> no pulse, txdrop=1.
- IO_IRQ_EN, DIV=2, write compare=3 -> irq rises at cnt1=3 and clears on read of index 4. Without the macro, irq stays 0 throughout.
